score_digit_ctrl: RTL

- Owns the player score and sequences reads of the 20x20 digit-sprite ROMs (one ROM per digit glyph 0-9, 10-bit address, 8-bit pixel data, 1-cycle synchronous read) for the on-screen score field.
- Counts score in BCD and latches a tear-free display copy at frame start.
- Maps the VGA pixel stream onto NUM_DIGITS digit boxes and drives ROM address plus glyph select.
- Returns a pixel aligned to a fixed 2-cycle latency for the top-level colour mux.

---
 rtl/score_digit_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/score_digit_ctrl.sv
// rtl/score_digit_ctrl.sv - BCD score counter and score-field digit-sprite ROM sequencer
//
// Purpose:
//   Keeps the player score as NUM_DIGITS BCD digits, snapshots a tear-free
//   display copy at each frame start, maps the pixel stream onto the row of
//   digit boxes, drives the glyph ROM address/select, and returns the score
//   pixel two cycles after the coordinates were presented.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - blank leading zero digits (least-significant digit
//                           is always drawn).
//
// Ports:
//   i_clk2         in   1    pixel clock
//   i_rst_n        in   1    asynchronous active-low reset
//   i_x, i_y       in   10   current pixel column / row
//   i_active       in   1    pixel is in the visible area
//   i_frame_start  in   1    pulse at the first pixel of a frame
//   i_score_inc    in   1    pulse: score += 1 (saturating)
//   i_score_clr    in   1    pulse: score := 0 (wins over increment)
//   o_numberaddr   out  10   glyph ROM address, row*DIGIT_W + col
//   o_digit_sel    out  4    glyph index 0-9 used to mux the ROM outputs
//   i_numberdata   in   8    muxed ROM data, one cycle after o_numberaddr
//   o_pixel        out  8    score pixel, 0 outside the glyphs
//   o_hit          out  1    o_pixel belongs to the score field
//   o_score        out  4*NUM_DIGITS  working BCD score, digit 0 in LSBs

module score_digit_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 20,
  parameter int DIGIT_H    = 20,
  parameter int DIGIT_GAP  = 2,
  parameter int ORIGIN_X   = 560,
  parameter int ORIGIN_Y   = 10
) (
  input  logic                    i_clk2,
  input  logic                    i_rst_n,
  input  logic [9:0]              i_x,
  input  logic [9:0]              i_y,
  input  logic                    i_active,
  input  logic                    i_frame_start,
  input  logic                    i_score_inc,
  input  logic                    i_score_clr,
  output logic [9:0]              o_numberaddr,
  output logic [3:0]              o_digit_sel,
  input  logic [7:0]              i_numberdata,
  output logic [7:0]              o_pixel,
  output logic                    o_hit,
  output logic [4*NUM_DIGITS-1:0] o_score
);

  localparam int SW    = 4 * NUM_DIGITS;
  localparam int PITCH = DIGIT_W + DIGIT_GAP;

  // Field bounds, widened to 11 bits so the x - ORIGIN_X subtraction below
  // never aliases a legal coordinate.
  localparam logic [10:0] X_LO  = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI  = 11'(ORIGIN_X + NUM_DIGITS * PITCH - DIGIT_GAP);
  localparam logic [10:0] Y_LO  = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI  = 11'(ORIGIN_Y + DIGIT_H);
  localparam logic [10:0] GW    = 11'(DIGIT_W);

  // ---------------------------------------------------------------------------
  // Working score: saturating BCD ripple counter
  // ---------------------------------------------------------------------------
  logic [SW-1:0] score_q;
  logic [SW-1:0] score_inc_val;
  logic          score_full;
  logic          carry;

  always_comb begin
    score_inc_val = score_q;
    score_full    = 1'b1;
    carry         = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (score_q[4*d +: 4] != 4'd9) begin
        score_full = 1'b0;
      end
      if (carry) begin
        if (score_q[4*d +: 4] == 4'd9) begin
          score_inc_val[4*d +: 4] = 4'd0;
        end else begin
          score_inc_val[4*d +: 4] = score_q[4*d +: 4] + 4'd1;
          carry                   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      score_q <= '0;
    end else if (i_score_clr) begin
      score_q <= '0;
    end else if (i_score_inc && !score_full) begin
      score_q <= score_inc_val;
    end
  end

  assign o_score = score_q;

  // ---------------------------------------------------------------------------
  // Display copy: sampled from the pre-update score at frame start so a
  // same-cycle increment lands in the next frame rather than tearing this one.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] disp_q;

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      disp_q <= '0;
    end else if (i_frame_start) begin
      disp_q <= score_q;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lz[j]: screen slot j (0 = leftmost) and every slot left of it hold zero.
  logic [NUM_DIGITS-1:0] lz;

  always_comb begin
    lz    = '0;
    lz[0] = (disp_q[4*(NUM_DIGITS-1) +: 4] == 4'd0);
    for (int j = 1; j < NUM_DIGITS; j++) begin
      lz[j] = lz[j-1] && (disp_q[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 0: locate the pixel inside the field (combinational)
  // ---------------------------------------------------------------------------
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_x;
  logic        in_y;

  assign x_ext = {1'b0, i_x};
  assign y_ext = {1'b0, i_y};
  assign dx    = x_ext - X_LO;
  assign dy    = y_ext - Y_LO;
  assign in_x  = (x_ext >= X_LO) && (x_ext < X_HI);
  assign in_y  = (y_ext >= Y_LO) && (y_ext < Y_HI);

  // Each slot owns a fixed dx window, so slot index and column fall out of
  // parallel compares against constants instead of a divide by the pitch.
  logic [10:0] slot_lo;
  logic [10:0] col0;
  logic [3:0]  sel0;
  logic        slot_hit;
  logic        blank0;

  always_comb begin
    slot_lo  = '0;
    col0     = '0;
    sel0     = '0;
    slot_hit = 1'b0;
    blank0   = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      slot_lo = 11'(j * PITCH);
      if ((dx >= slot_lo) && (dx < slot_lo + GW)) begin
        slot_hit = 1'b1;
        col0     = dx - slot_lo;
        sel0     = disp_q[4*(NUM_DIGITS-1-j) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank0   = lz[j] && (j != NUM_DIGITS - 1);
`endif
      end
    end
  end

  logic        hit0;
  logic [10:0] addr_wide;

  assign hit0      = i_active && in_y && in_x && slot_hit;
  assign addr_wide = dy * GW + col0;

  // ---------------------------------------------------------------------------
  // Stage 1: ROM address / glyph select. They only move on a hit so the ROM
  // bus stays quiet outside the score field.
  // ---------------------------------------------------------------------------
  logic hit1;

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_numberaddr <= '0;
      o_digit_sel  <= '0;
      hit1         <= 1'b0;
    end else begin
      hit1 <= hit0 && !blank0;
      if (hit0) begin
        o_numberaddr <= addr_wide[9:0];
        o_digit_sel  <= sel0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: the ROM data arrives this cycle, so only the hit flag needs a
  // register; the pixel gate is combinational on the returned data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit <= 1'b0;
    end else begin
      o_hit <= hit1;
    end
  end

  assign o_pixel = o_hit ? i_numberdata : 8'd0;

endmodule
